bus_initiator: RTL and testbench

- Bus master for the daisy-chained register bus (addr/wdata/rdata/rw/valid) that the cores (e.g. bram_core) respond on.
- Accepts one read or write command at a time on a ready/valid command port and drives a single-cycle request onto the bus.
- Waits for the request to return around the chain, then presents read data and status on a ready/valid response port.
- Sits between the host bridge (UART/Ethernet decoder) and the first core in the chain.

---
 rtl/bus_pkg.sv | 28 ++
 rtl/bus_initiator.sv | 149 ++++++++++++++
 tb/tb_bus_initiator.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and default widths for the daisy-chained register bus.
// Used by the bus initiator and by the cores that respond on the chain.
package bus_pkg;

  localparam int unsigned BusAddrW = 16;
  localparam int unsigned BusDataW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } initiator_state_t;

  typedef struct packed {
    logic [BusAddrW-1:0] addr;
    logic [BusDataW-1:0] wdata;
    logic                rw;
    logic                valid;
  } bus_req_t;

  function automatic bus_req_t bus_req_idle();
    bus_req_t req;
    req = '0;
    return req;
  endfunction

endpackage

// File: rtl/bus_initiator.sv
// Bus master: issues one request per command onto the register chain, waits for it to return,
// then presents data/status on a response port. BUS_INITIATOR_CHECK_EN adds return checking.
module bus_initiator
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = BusAddrW,
  parameter int unsigned DATA_W  = BusDataW,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  // Command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // Response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              rsp_error,
  // Outgoing bus request
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rw_o,
  output logic              valid_o,
  // Returning bus request
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              rw_i,
  input  logic              valid_i
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  initiator_state_t  state_q;
  logic [CntW-1:0]   cnt_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;

  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_timeout_q;
  logic              rsp_error_q;

  logic              req_valid_q;
  logic              req_rw_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;

  logic              ret_mismatch;

`ifdef BUS_INITIATOR_CHECK_EN
  logic unused_ret;
  assign ret_mismatch = (addr_i != addr_q) || (rw_i != rw_q);
  assign unused_ret   = ^wdata_i;
`else
  logic unused_ret;
  assign ret_mismatch = 1'b0;
  assign unused_ret   = ^{wdata_i, addr_i, rw_i, addr_q};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      rw_q          <= 1'b0;
      addr_q        <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_error_q   <= 1'b0;
      req_valid_q   <= 1'b0;
      req_rw_q      <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            rw_q        <= cmd_rw;
            addr_q      <= cmd_addr;
            cmd_ready_q <= 1'b0;
            // Request registers load here so valid_o rises the cycle after acceptance.
            req_valid_q <= 1'b1;
            req_rw_q    <= cmd_rw;
            req_addr_q  <= cmd_addr;
            req_wdata_q <= cmd_rw ? cmd_wdata : '0;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          req_valid_q <= 1'b0;
          req_rw_q    <= 1'b0;
          req_addr_q  <= '0;
          req_wdata_q <= '0;
          cnt_q       <= '0;
          state_q     <= StWait;
        end
        StWait: begin
          // A return in the expiry cycle still counts as a normal completion.
          if (valid_i) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= rw_q ? '0 : rdata_i;
            rsp_timeout_q <= 1'b0;
            rsp_error_q   <= ret_mismatch;
            state_q       <= StResp;
          end else if (cnt_q == CntLast) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b1;
            rsp_error_q   <= 1'b0;
            state_q       <= StResp;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_error   = rsp_error_q;

  assign valid_o = req_valid_q;
  assign rw_o    = req_rw_q;
  assign addr_o  = req_addr_q;
  assign wdata_o = req_wdata_q;
  assign rdata_o = '0;

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: directed vector table, randomized transactions against
// a memory reference model, and a mid-transaction reset sequence. Loopback chain emulated here.
module tb_bus_initiator;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 8;
`ifdef BUS_INITIATOR_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_rw;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_timeout, rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] addr_o, addr_i;
  logic [DW-1:0] wdata_o, rdata_o, wdata_i, rdata_i;
  logic          rw_o, valid_o, rw_i, valid_i;

  bus_initiator #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rw     (cmd_rw),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .rsp_error  (rsp_error),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .rdata_o    (rdata_o),
    .rw_o       (rw_o),
    .valid_o    (valid_o),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_i    (rdata_i),
    .rw_i       (rw_i),
    .valid_i    (valid_i)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // bram: what the emulated chain stores; ref_mem: what the command stream says should be there.
  logic [DW-1:0] bram    [16];
  logic [DW-1:0] ref_mem [16];

  typedef struct {
    bit            rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            delay;
    bit            corrupt;
    int            hold;
    logic [DW-1:0] exp_rdata;
    bit            exp_to;
    bit            exp_err_chk;
    int            exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cmd_ready"},   32'(cmd_ready),   32'd1);
    chk({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
    chk({tag, "_rsp_rdata"},   32'(rsp_rdata),   32'd0);
    chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    chk({tag, "_rsp_error"},   32'(rsp_error),   32'd0);
    chk({tag, "_valid_o"},     32'(valid_o),     32'd0);
    chk({tag, "_rw_o"},        32'(rw_o),        32'd0);
    chk({tag, "_addr_o"},      32'(addr_o),      32'd0);
    chk({tag, "_wdata_o"},     32'(wdata_o),     32'd0);
    chk({tag, "_rdata_o"},     32'(rdata_o),     32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_txn(input bit rw, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int delay, input bit corrupt, input int hold,
                         input logic [DW-1:0] exp_rdata, input bit exp_to, input bit exp_err,
                         input int exp_lat);
    logic [AW-1:0] iss_addr;
    bit            iss_rw;
    int            lat;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = 16'($urandom);
    cmd_wdata = 16'($urandom);
    chk("issue_valid_o", 32'(valid_o), 32'd1);
    chk("issue_rw_o",    32'(rw_o),    32'(rw));
    chk("issue_addr_o",  32'(addr_o),  32'(addr));
    chk("issue_wdata_o", 32'(wdata_o), rw ? 32'(wdata) : 32'd0);
    chk("issue_rdata_o", 32'(rdata_o), 32'd0);
    chk("issue_cmd_ready", 32'(cmd_ready), 32'd0);
    iss_addr = addr_o;
    iss_rw   = rw_o;
    if (valid_o && rw_o) bram[addr_o[3:0]] = wdata_o;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rsp_valid) lat = k;
      else chk("wait_valid_o", 32'(valid_o), 32'd0);
      if (k == delay) begin
        valid_i = 1'b1;
        rw_i    = iss_rw;
        addr_i  = corrupt ? (iss_addr ^ 16'h0003) : iss_addr;
        rdata_i = iss_rw ? 16'hDEAD : bram[iss_addr[3:0]];
      end else begin
        valid_i = 1'b0;
        rw_i    = 1'($urandom);
        addr_i  = 16'($urandom);
        rdata_i = 16'($urandom);
      end
      if (lat >= 0) break;
    end
    chk("rsp_latency", 32'(lat), 32'(exp_lat));
    chk("rsp_rdata",   32'(rsp_rdata),   32'(exp_rdata));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
    chk("rsp_error",   32'(rsp_error),   32'(exp_err));
    chk("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      valid_i   = 1'b0;
      cmd_valid = 1'b1;
      cmd_rw    = 1'($urandom);
      cmd_addr  = 16'($urandom);
      chk("hold_rsp_valid",   32'(rsp_valid),   32'd1);
      chk("hold_rsp_rdata",   32'(rsp_rdata),   32'(exp_rdata));
      chk("hold_rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
      chk("hold_rsp_error",   32'(rsp_error),   32'(exp_err));
      chk("hold_cmd_ready",   32'(cmd_ready),   32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    valid_i   = 1'b0;
    rsp_ready = 1'b0;
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("done_valid_o",   32'(valid_o),   32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            rw, corrupt, to;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, exp_rd;
    int            delay, hold;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    valid_i   = 1'b0;
    rw_i      = 1'b0;
    addr_i    = '0;
    wdata_i   = '0;
    rdata_i   = '0;
    for (int i = 0; i < 16; i++) begin
      bram[i]    = '0;
      ref_mem[i] = '0;
    end

    //           rw addr      wdata     dly cor hold exp_rdata to err lat
    vecs[0] = '{1, 16'h0000, 16'h0004, 0,  0,  0,   16'h0000, 0, 0, 1};
    vecs[1] = '{0, 16'h0000, 16'h0000, 2,  0,  0,   16'h0004, 0, 0, 3};
    vecs[2] = '{1, 16'h0001, 16'h0003, 1,  0,  0,   16'h0000, 0, 0, 2};
    vecs[3] = '{0, 16'h0001, 16'h5555, 7,  0,  0,   16'h0003, 0, 0, 8};
    vecs[4] = '{0, 16'h0000, 16'h0000, 8,  0,  2,   16'h0000, 1, 0, 8};
    vecs[5] = '{1, 16'h0002, 16'h00AA, 20, 0,  5,   16'h0000, 1, 0, 8};
    vecs[6] = '{0, 16'h0001, 16'h0000, 0,  0,  5,   16'h0003, 0, 0, 1};
    vecs[7] = '{0, 16'h0001, 16'h0000, 0,  1,  1,   16'h0003, 0, 1, 1};
    vecs[8] = '{0, 16'h0002, 16'h0000, 3,  0,  0,   16'h00AA, 0, 0, 4};
    vecs[9] = '{1, 16'h0003, 16'h1234, 4,  1,  0,   16'h0000, 0, 1, 5};

    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].delay, vecs[i].corrupt,
              vecs[i].hold, vecs[i].exp_rdata, vecs[i].exp_to, vecs[i].exp_err_chk && CheckEn,
              vecs[i].exp_lat);
      if (vecs[i].rw) ref_mem[vecs[i].addr[3:0]] = vecs[i].wdata;
    end

    for (int i = 0; i < 40; i++) begin
      rw      = 1'($urandom);
      addr    = 16'($urandom);
      wdata   = 16'($urandom);
      delay   = int'($urandom_range(0, 10));
      corrupt = ($urandom_range(0, 7) == 0);
      hold    = int'($urandom_range(0, 2));
      to      = (delay >= int'(TO));
      exp_rd  = (!to && !rw) ? ref_mem[addr[3:0]] : '0;
      run_txn(rw, addr, wdata, delay, corrupt, hold, exp_rd, to, CheckEn && corrupt && !to,
              to ? int'(TO) : delay + 1);
      if (rw) ref_mem[addr[3:0]] = wdata;
    end

    // Reset while waiting for a return; the late return must be ignored.
    cmd_valid = 1'b1;
    cmd_rw    = 1'b0;
    cmd_addr  = 16'h0001;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_idle("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    valid_i = 1'b1;
    rw_i    = 1'b0;
    addr_i  = 16'h0001;
    rdata_i = 16'h1234;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk_idle("after_reset");
    end
    run_txn(1'b0, 16'h0001, 16'h0000, 1, 1'b0, 0, ref_mem[1], 1'b0, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
